// File: rtl/serial_add_seq.sv
// serial_add_seq: bit-serial adder sequencer.
// Streams two WIDTH-bit operands LSB-first through an external 1-bit full
// adder, one bit per clock, and assembles sum, unsigned carry-out and signed
// overflow. States: IDLE -> RUN (WIDTH cycles) -> DONE (one cycle).
module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_ci,
    input  logic             fa_s,
    input  logic             fa_co,
    output logic             fa_en,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum_sh;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic             w_accept;
    logic             w_run;
    logic             w_last;

    assign w_run    = (r_state == S_RUN);
    // Start is only honoured when no operation is in flight.
    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = (r_cnt == LAST_BIT);

    // Next-state selection for the IDLE/RUN/DONE sequencer.
    always_comb begin
        w_state_nxt = S_IDLE;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_DONE: begin
                if (w_accept) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Full-adder operand drive: current LSBs and carry in RUN, quiet otherwise.
    always_comb begin
        fa_a  = 1'b0;
        fa_b  = 1'b0;
        fa_ci = 1'b0;
        if (w_run) begin
            fa_a  = r_a_sh[0];
            fa_b  = r_b_sh[0];
            fa_ci = r_carry;
        end else begin
            fa_a  = 1'b0;
            fa_b  = 1'b0;
            fa_ci = 1'b0;
        end
    end

    assign busy  = w_run;
    assign fa_en = w_run;
    assign done  = (r_state == S_DONE);
    assign sum   = r_sum;
    assign cout  = r_cout;
    assign ovf   = r_ovf;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand shift registers, running carry, partial sum and bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_a_sh   <= a;
            r_b_sh   <= b;
            r_sum_sh <= '0;
            r_carry  <= cin;
            r_cnt    <= '0;
        end else if (w_run) begin
            r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
            r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
            r_sum_sh <= {fa_s, r_sum_sh[WIDTH-1:1]};
            r_carry  <= fa_co;
            r_cnt    <= r_cnt + CW'(1);
        end else begin
            r_a_sh   <= r_a_sh;
            r_b_sh   <= r_b_sh;
            r_sum_sh <= r_sum_sh;
            r_carry  <= r_carry;
            r_cnt    <= r_cnt;
        end
    end

    // Result registers: loaded only on the edge that processes the MSB.
    // At that edge r_carry still holds the carry into the MSB, so overflow
    // is that carry XOR the carry out of the MSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_run && w_last) begin
            r_sum  <= {fa_s, r_sum_sh[WIDTH-1:1]};
            r_cout <= fa_co;
            r_ovf  <= r_carry ^ fa_co;
        end else begin
            r_sum  <= r_sum;
            r_cout <= r_cout;
            r_ovf  <= r_ovf;
        end
    end

endmodule

// File: doc/serial_add_seq.md
SERIAL_ADD_SEQ -- requirements
Module: serial_add_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port start  input  1  request to begin an addition.
REQ-005 SHALL have ports a, b  input  WIDTH  operands, sampled only on an accepted start.
REQ-006 SHALL have port cin  input  1  carry-in, sampled only on an accepted start.
REQ-007 SHALL have ports fa_a, fa_b, fa_ci  output  1  bit operands and carry driven to the external 1-bit full adder.
REQ-008 SHALL have ports fa_s, fa_co  input  1  sum and carry returned combinationally by the external full adder.
REQ-009 SHALL have port fa_en  output  1  high while a bit is being processed.
REQ-010 SHALL have port busy  output  1  high while an operation is in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse marking a completed result.
REQ-012 SHALL have ports sum  output  WIDTH, cout  output  1, ovf  output  1  result, unsigned carry-out, signed overflow.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 In IDLE or DONE, start=1 at a rising edge SHALL be accepted: a, b, cin latched into internal shift/carry registers, bit counter cleared to 0, next state RUN.
REQ-015 start SHALL be ignored in RUN; latched operands and progress SHALL be unaffected.
REQ-016 In RUN, fa_a/fa_b SHALL be the current LSB of the operand shift registers, fa_ci the carry register, fa_en=1.
REQ-017 At each RUN edge: fa_s shifted into sum register at bit WIDTH-1 (LSB-first result), carry register <= fa_co, operand registers shifted right one, counter incremented.
REQ-018 Carry register value before processing bit WIDTH-1 SHALL be retained as the MSB carry-in for ovf.
REQ-019 After the edge processing bit WIDTH-1, next state SHALL be DONE; RUN lasts exactly WIDTH cycles.
REQ-020 In DONE, done=1 for exactly one cycle; next state IDLE unless start accepted (back-to-back permitted).
REQ-021 Latency: start accepted at edge E0 -> done high in the cycle after edge E(WIDTH), i.e. WIDTH+1 edges after acceptance.
REQ-022 busy SHALL equal (state==RUN); fa_en SHALL equal busy.
REQ-023 Outside RUN, fa_a, fa_b, fa_ci SHALL be 0.
REQ-024 sum, cout, ovf SHALL update only on the final RUN edge and hold until the next completion; cout = final carry register, ovf = MSB carry-in XOR cout.
REQ-025 Arithmetic SHALL equal {cout,sum} = a + b + cin modulo 2^(WIDTH+1).

Reset
REQ-026 rst=1 SHALL immediately force state IDLE, counter 0, internal registers 0, and sum=0, cout=0, ovf=0, busy=0, done=0, fa_en=0, fa_a=fa_b=fa_ci=0.
REQ-027 Reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow, and previous results SHALL be cleared.
REQ-028 First start SHALL be accepted at the first rising edge after rst deasserts.

Verification (WIDTH=8, bench models the external full adder)
REQ-029 a=8'h0F, b=8'h01, cin=0, start one cycle -> busy high 8 cycles, done pulse 9 edges after acceptance, sum=8'h10, cout=0, ovf=0.
REQ-030 a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, ovf=0; a=8'h7F, b=8'h01 -> sum=8'h80, cout=0, ovf=1.
REQ-031 a=8'hAA, b=8'h55, cin=1 -> sum=8'h00, cout=1; start pulsed with a=8'h01 during RUN -> result unchanged, no extra done.
REQ-032 rst pulsed after 4 RUN cycles -> all outputs 0 immediately, no done; subsequent start with 8'h03+8'h04 -> sum=8'h07.
REQ-033 start held high continuously with fixed operands 8'h10+8'h20 -> done every 9 cycles, sum=8'h30 each time, busy low only in DONE cycles.
REQ-034 Random 1000 operand pairs, random cin -> {cout,sum} matches a+b+cin, ovf matches signed-overflow reference.
